reg_file_mp: RTL and testbench

Parametrised multi-read-port register file for the datapath. It stores 2^ADDR_W words of WIDTH bits and has one write port and NUM_RD independent read ports. Options cover a hardwired-zero register 0, write-to-read bypass, combinational or registered read data, and a synchronous bulk clear. It replaces the fixed 32-input read select with a per-port generated read path.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/rf_read_port.sv | 60 ++++++
 rtl/reg_file_mp.sv | 66 ++++++
 tb/tb_reg_file_mp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and slice helper for the multi-port register file.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package reg_file_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

  // Low bit of slice idx inside a bus packed from w-bit fields.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: address select over flat storage, zero/clear/bypass override.
// Latency: 0 cycles (combinational) or 1 cycle when RD_LATENCY=1.
// Backpressure: none; Re only gates the optional output register.
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH      = RF_WIDTH,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  parameter int RD_LATENCY = 0
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           Clr,
  input  logic                           We,
  input  logic [ADDR_W-1:0]              Waddr,
  input  logic [WIDTH-1:0]               Wdata,
  input  logic [(2**ADDR_W)*WIDTH-1:0]   mem_flat,
  input  logic                           Re,
  input  logic [ADDR_W-1:0]              Raddr,
  output logic [WIDTH-1:0]               Rdata
);

  logic             zero_hit;
  logic             byp_hit;
  logic [WIDTH-1:0] rd_val;

  // Priority: hardwired zero, then clear, then write forwarding, then storage.
  always_comb begin
    zero_hit = ZERO_REG && (Raddr == '0);
    byp_hit  = BYPASS && We && (Waddr == Raddr);
    if (zero_hit || Clr) begin
      rd_val = '0;
    end else if (byp_hit) begin
      rd_val = Wdata;
    end else begin
      rd_val = mem_flat[slice_lo(int'(Raddr), WIDTH) +: WIDTH];
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_comb
      logic unused_ok;
      assign unused_ok = ^{Clk, Rst_n, Re};
      assign Rdata     = rd_val;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_q;
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          rd_q <= '0;
        end else if (Re) begin
          rd_q <= rd_val;
        end
      end
      assign Rdata = rd_q;
    end
  endgenerate

endmodule

// File: rtl/reg_file_mp.sv
// Register file: one write port, NUM_RD independent read ports, bulk clear.
// Latency: write visible next cycle (same cycle with bypass); read 0 or 1 cycle.
// Backpressure: none; every port accepts a request every cycle.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH      = RF_WIDTH,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  parameter int RD_LATENCY = 0
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Clr,
  input  logic                     We,
  input  logic [ADDR_W-1:0]        Waddr,
  input  logic [WIDTH-1:0]         Wdata,
  input  logic [NUM_RD-1:0]        Re,
  input  logic [NUM_RD*ADDR_W-1:0] Raddr,
  output logic [NUM_RD*WIDTH-1:0]  Rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic                   wr_en;

  // Entry 0 never takes a write when hardwired, so it stays zero in storage.
  assign wr_en = We && !(ZERO_REG && (Waddr == '0));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_flat <= '0;
    end else if (Clr) begin
      mem_flat <= '0;
    end else if (wr_en) begin
      mem_flat[slice_lo(int'(Waddr), WIDTH) +: WIDTH] <= Wdata;
    end
  end

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      rf_read_port #(
        .WIDTH      (WIDTH),
        .ADDR_W     (ADDR_W),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS),
        .RD_LATENCY (RD_LATENCY)
      ) u_port (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Clr      (Clr),
        .We       (We),
        .Waddr    (Waddr),
        .Wdata    (Wdata),
        .mem_flat (mem_flat),
        .Re       (Re[i]),
        .Raddr    (Raddr[slice_lo(i, ADDR_W) +: ADDR_W]),
        .Rdata    (Rdata[slice_lo(i, WIDTH) +: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: four parameter sets driven in lockstep against an array model.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_file_mp;

  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;
  localparam int NCFG  = 4;

  logic           Clk = 1'b0;
  logic           Rst_n;
  logic           Clr;
  logic           We;
  logic [AW-1:0]  Waddr;
  logic [W-1:0]   Wdata;
  logic [NR-1:0]  Re;
  logic [NR*AW-1:0] Raddr;
  logic [NR*W-1:0]  rd_a, rd_b, rd_c, rd_d;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] mdl_mem [NCFG][DEPTH];
  logic [W-1:0] mdl_q   [NCFG][NR];

  always #5 Clk = ~Clk;

  // cfg0: zero+bypass comb, cfg1: zero comb no bypass, cfg2: zero+bypass registered,
  // cfg3: no zero reg, no bypass, registered.
  reg_file_mp #(.ZERO_REG(1'b1), .BYPASS(1'b1), .RD_LATENCY(0)) u_a (
    .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .We(We), .Waddr(Waddr), .Wdata(Wdata),
    .Re(Re), .Raddr(Raddr), .Rdata(rd_a));
  reg_file_mp #(.ZERO_REG(1'b1), .BYPASS(1'b0), .RD_LATENCY(0)) u_b (
    .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .We(We), .Waddr(Waddr), .Wdata(Wdata),
    .Re(Re), .Raddr(Raddr), .Rdata(rd_b));
  reg_file_mp #(.ZERO_REG(1'b1), .BYPASS(1'b1), .RD_LATENCY(1)) u_c (
    .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .We(We), .Waddr(Waddr), .Wdata(Wdata),
    .Re(Re), .Raddr(Raddr), .Rdata(rd_c));
  reg_file_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0), .RD_LATENCY(1)) u_d (
    .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .We(We), .Waddr(Waddr), .Wdata(Wdata),
    .Re(Re), .Raddr(Raddr), .Rdata(rd_d));

  function automatic bit cfg_zr(input int c);
    return c != 3;
  endfunction

  function automatic bit cfg_byp(input int c);
    return (c == 0) || (c == 2);
  endfunction

  function automatic bit cfg_lat(input int c);
    return c >= 2;
  endfunction

  function automatic logic [W-1:0] dut_port(input int c, input int p);
    logic [NR*W-1:0] v;
    case (c)
      0:       v = rd_a;
      1:       v = rd_b;
      2:       v = rd_c;
      default: v = rd_d;
    endcase
    return v[p*W +: W];
  endfunction

  function automatic logic [AW-1:0] ra(input int p);
    logic [NR*AW-1:0] v;
    v = Raddr;
    return v[p*AW +: AW];
  endfunction

  // Value a read of address a sees this cycle under config c.
  function automatic logic [W-1:0] model_read(input int c, input logic [AW-1:0] a);
    if (cfg_zr(c) && a == '0) return '0;
    if (Clr) return '0;
    if (cfg_byp(c) && We && Waddr == a) return Wdata;
    return mdl_mem[c][a];
  endfunction

  function automatic logic [W-1:0] model_out(input int c, input int p);
    if (cfg_lat(c)) return mdl_q[c][p];
    return model_read(c, ra(p));
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int c = 0; c < NCFG; c++) begin
        for (int a = 0; a < DEPTH; a++) mdl_mem[c][a] = '0;
        for (int p = 0; p < NR; p++) mdl_q[c][p] = '0;
      end
    end else begin
      for (int c = 0; c < NCFG; c++) begin
        for (int p = 0; p < NR; p++)
          if (Re[p]) mdl_q[c][p] = model_read(c, ra(p));
        if (Clr) begin
          for (int a = 0; a < DEPTH; a++) mdl_mem[c][a] = '0;
        end else if (We && !(cfg_zr(c) && Waddr == '0)) begin
          mdl_mem[c][Waddr] = Wdata;
        end
      end
    end
  end

  always @(negedge Clk) begin
    for (int c = 0; c < NCFG; c++)
      for (int p = 0; p < NR; p++)
        check($sformatf("model_cfg%0d_p%0d", c, p), dut_port(c, p), model_out(c, p));
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    Raddr[p*AW +: AW] = a;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    We = 1'b1; Waddr = a; Wdata = d;
    step();
    We = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; Clr = 1'b0; We = 1'b0; Waddr = '0; Wdata = '0; Re = '0; Raddr = '0;
    set_ra(0, 5'd5); set_ra(1, 5'd31);
    #2;
    check("reset_a_p0", dut_port(0, 0), 32'h0);
    check("reset_a_p1", dut_port(0, 1), 32'h0);
    check("reset_c_p1", dut_port(2, 1), 32'h0);
    #10 Rst_n = 1'b1;
    step();
    for (int a = 0; a < DEPTH; a++) begin
      set_ra(0, AW'(a)); set_ra(1, AW'(a));
      #1;
      check("reset_entry_zero", dut_port(3, 0) | dut_port(0, 1), 32'h0);
    end
    step();

    wr(5'd7, 32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    set_ra(0, 5'd7); set_ra(1, 5'd31);
    #1;
    check("readback_p0", dut_port(0, 0), 32'hDEADBEEF);
    check("readback_p1", dut_port(0, 1), 32'h12345678);
    Re = 2'b11;
    step();
    Re = 2'b00;
    check("reg_readback_p0", dut_port(2, 0), 32'hDEADBEEF);
    check("reg_readback_p1", dut_port(3, 1), 32'h12345678);

    We = 1'b1; Waddr = '0; Wdata = 32'hFFFFFFFF;
    set_ra(0, '0); set_ra(1, '0);
    #1;
    check("zero_same_p0", dut_port(0, 0), 32'h0);
    check("zero_same_p1", dut_port(0, 1), 32'h0);
    step();
    We = 1'b0;
    #1;
    check("zero_next_a", dut_port(0, 0), 32'h0);
    check("zero_next_b", dut_port(1, 1), 32'h0);
    Re = 2'b01;
    step();
    Re = 2'b00;
    check("zero_reg_c", dut_port(2, 0), 32'h0);
    check("no_zero_reg_d", dut_port(3, 0), 32'hFFFFFFFF);

    wr(5'd3, 32'h1111);
    We = 1'b1; Waddr = 5'd3; Wdata = 32'h2222; Re = 2'b01;
    set_ra(0, 5'd3);
    #1;
    check("bypass_on", dut_port(0, 0), 32'h2222);
    check("bypass_off", dut_port(1, 0), 32'h1111);
    step();
    We = 1'b0; Re = 2'b00;
    #1;
    check("after_coll_a", dut_port(0, 0), 32'h2222);
    check("after_coll_b", dut_port(1, 0), 32'h2222);
    check("write_first_c", dut_port(2, 0), 32'h2222);
    check("read_first_d", dut_port(3, 0), 32'h1111);

    wr(5'd9, 32'hA5A5);
    set_ra(0, 5'd9); Re = 2'b01;
    step();
    Re = 2'b00; set_ra(0, 5'd2);
    #1;
    check("reg_read_c", dut_port(2, 0), 32'hA5A5);
    step();
    check("reg_hold_c", dut_port(2, 0), 32'hA5A5);
    check("reg_hold_d", dut_port(3, 0), 32'hA5A5);

    for (int a = 1; a < DEPTH; a++) wr(AW'(a), W'(a));
    Clr = 1'b1; We = 1'b1; Waddr = 5'd4; Wdata = 32'h77; Re = 2'b11;
    set_ra(0, 5'd4); set_ra(1, 5'd4);
    #1;
    check("clr_same_cycle_a", dut_port(0, 0), 32'h0);
    check("clr_same_cycle_b", dut_port(1, 1), 32'h0);
    step();
    Clr = 1'b0; We = 1'b0; Re = 2'b00;
    check("clr_first_c", dut_port(2, 0), 32'h0);
    check("clr_first_d", dut_port(3, 1), 32'h0);
    for (int a = 1; a < DEPTH; a++) begin
      set_ra(0, AW'(a)); set_ra(1, AW'(a));
      #1;
      check("clr_entry_a", dut_port(0, 0), 32'h0);
      check("clr_entry_b", dut_port(1, 1), 32'h0);
    end

    wr(5'd5, 32'h55);
    set_ra(0, 5'd5); set_ra(1, 5'd5); Re = 2'b11;
    step();
    Re = 2'b00;
    check("pre_rst_c", dut_port(2, 0), 32'h55);
    check("pre_rst_d", dut_port(3, 1), 32'h55);
    @(posedge Clk);
    #3 Rst_n = 1'b0;
    #1;
    check("mid_rst_c", dut_port(2, 0), 32'h0);
    check("mid_rst_d", dut_port(3, 1), 32'h0);
    check("mid_rst_a", dut_port(0, 0), 32'h0);
    #3 Rst_n = 1'b1;
    step();

    repeat (800) begin
      Clr   = ($urandom_range(0, 31) == 0);
      We    = 1'($urandom_range(0, 1));
      Waddr = AW'($urandom_range(0, DEPTH - 1));
      Wdata = $urandom;
      Re    = NR'($urandom_range(0, 3));
      for (int p = 0; p < NR; p++) begin
        if ($urandom_range(0, 3) == 0) set_ra(p, Waddr);
        else set_ra(p, AW'($urandom_range(0, DEPTH - 1)));
      end
      step();
    end
    Clr = 1'b0; We = 1'b0; Re = '0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
